bus_arbiter_mux: RTL and testbench

Parametrised, registered successor to the combinational common-bus selector of the basic computer. It drives the shared bus from one of NSRC sources. It runs in one of two modes:
- Legacy mode: the source is picked by an encoded select, as the control unit does today.
- Arbitration mode: sources raise requests and the block grants them round-robin, with an optional bus lock.
Source 0 is reserved as "no source". Slow sources such as memory stall the transfer via a per-source ready line, with a timeout.

---
 rtl/bus_arbiter_mux.sv | 204 ++++++++++++++++++++
 tb/tb_bus_arbiter_mux.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// Registered common-bus source selector: legacy encoded select or round-robin
// request arbitration with optional lock, per-source ready stalls and a wait timeout.
module bus_arbiter_mux #(
    parameter int DATA_W   = 16,
    parameter int NSRC     = 8,
    parameter int SEL_W    = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [NSRC-1:0]        req,
    input  logic                   lock,
    input  logic [NSRC-1:0]        src_rdy,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic                   err_clr,
    output logic [DATA_W-1:0]      bus_data,
    output logic                   bus_valid,
    output logic [NSRC-1:0]        grant,
    output logic [SEL_W-1:0]       owner,
    output logic                   err_sel,
    output logic                   err_timeout
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q;
    logic [DATA_W-1:0]  bus_data_q, bus_data_d;
    logic               bus_valid_q, bus_valid_d;
    logic [NSRC-1:0]    grant_q, grant_d;
    logic               err_sel_q, err_sel_d;
    logic               err_timeout_q, err_timeout_d;

    logic               xfer_en;
    logic [SEL_W-1:0]   xfer_idx;
    logic               set_sel;
    logic               set_timeout;
    logic               do_pick;

    logic [DATA_W-1:0]  src_word [NSRC];
    logic [SEL_W-1:0]   pick_hi, pick_lo, pick_idx;
    logic               found_hi, found_lo, pick_found;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_word[i] = src_data[i*DATA_W +: DATA_W];
        end
    end

    // Round robin: lowest requester above last wins, else lowest at or below last.
    // Scanning downward lets the last hit in each half be the lowest index.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = NSRC - 1; i >= 1; i--) begin
            if (req[i]) begin
                if (SEL_W'(i) > last_q) begin
                    pick_hi  = SEL_W'(i);
                    found_hi = 1'b1;
                end else begin
                    pick_lo  = SEL_W'(i);
                    found_lo = 1'b1;
                end
            end
        end
        pick_found = found_hi | found_lo;
        pick_idx   = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        xfer_en     = 1'b0;
        xfer_idx    = owner_q;
        set_sel     = 1'b0;
        set_timeout = 1'b0;
        do_pick     = 1'b0;

        if (mode != mode_q) begin
            // Mode switch edge: drop everything, new mode acts from the next edge.
            state_d = ST_IDLE;
            owner_d = '0;
        end else if (!mode) begin
            state_d = ST_IDLE;
            if (sel == '0) begin
                owner_d = '0;
            end else if (int'(sel) >= NSRC) begin
                owner_d = '0;
                set_sel = 1'b1;
            end else begin
                owner_d  = sel;
                xfer_idx = sel;
                xfer_en  = src_rdy[sel];
            end
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (src_rdy[owner_q]) begin
                        xfer_en = 1'b1;
                        state_d = ST_XFER;
                    end else if (!req[owner_q]) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                    end else if (cnt_q == CNT_W'(WAIT_MAX)) begin
                        set_timeout = 1'b1;
                        state_d     = ST_IDLE;
                        owner_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (lock && req[owner_q]) begin
                        if (src_rdy[owner_q]) begin
                            xfer_en = 1'b1;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = ST_WAIT;
                        end
                    end else begin
                        do_pick = 1'b1;
                    end
                end
                default: do_pick = 1'b1;
            endcase

            if (do_pick) begin
                if (pick_found) begin
                    owner_d  = pick_idx;
                    last_d   = pick_idx;
                    xfer_idx = pick_idx;
                    if (src_rdy[pick_idx]) begin
                        xfer_en = 1'b1;
                        state_d = ST_XFER;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_WAIT;
                    end
                end else begin
                    owner_d = '0;
                    state_d = ST_IDLE;
                end
            end
        end

        // Grant is derived from owner so the two can never disagree.
        grant_d       = (owner_d == '0) ? '0 : ({{(NSRC-1){1'b0}}, 1'b1} << owner_d);
        bus_valid_d   = xfer_en;
        bus_data_d    = xfer_en ? src_word[xfer_idx] : bus_data_q;
        err_sel_d     = set_sel | (err_sel_q & ~err_clr);
        err_timeout_d = set_timeout | (err_timeout_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_q        <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            mode_q        <= 1'b0;
            bus_data_q    <= '0;
            bus_valid_q   <= 1'b0;
            grant_q       <= '0;
            err_sel_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode;
            bus_data_q    <= bus_data_d;
            bus_valid_q   <= bus_valid_d;
            grant_q       <= grant_d;
            err_sel_q     <= err_sel_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus_data    = bus_data_q;
    assign bus_valid   = bus_valid_q;
    assign grant       = grant_q;
    assign owner       = owner_q;
    assign err_sel     = err_sel_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: an 8-slot and a 6-slot instance share one stimulus
// stream; a behavioural model feeds a scoreboard queue checked after every edge.
module tb_bus_arbiter_mux;

    localparam int WAIT_MAX = 15;

    logic         clk;
    logic         rst_n;
    logic         mode;
    logic [2:0]   sel;
    logic [7:0]   req;
    logic         lock;
    logic [7:0]   src_rdy;
    logic [127:0] src_data;
    logic         err_clr;
    logic         beef_mode;

    logic [15:0]  bus_data8, bus_data6;
    logic         bus_valid8, bus_valid6;
    logic [7:0]   grant8;
    logic [5:0]   grant6;
    logic [2:0]   owner8, owner6;
    logic         err_sel8, err_sel6, err_to8, err_to6;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] bus_data;
        logic        bus_valid;
        logic [7:0]  grant;
        logic [2:0]  owner;
        logic        err_sel;
        logic        err_to;
        int          fsm;   // 0 idle, 1 wait, 2 xfer
        int          last;
        int          cnt;
        logic        mode_prev;
    } mstate_t;

    mstate_t m8, m6;
    mstate_t q8[$];
    mstate_t q6[$];

    bus_arbiter_mux #(.DATA_W(16), .NSRC(8), .SEL_W(3), .WAIT_MAX(WAIT_MAX)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .req(req), .lock(lock),
        .src_rdy(src_rdy), .src_data(src_data), .err_clr(err_clr),
        .bus_data(bus_data8), .bus_valid(bus_valid8), .grant(grant8), .owner(owner8),
        .err_sel(err_sel8), .err_timeout(err_to8)
    );

    bus_arbiter_mux #(.DATA_W(16), .NSRC(6), .SEL_W(3), .WAIT_MAX(WAIT_MAX)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .req(req[5:0]), .lock(lock),
        .src_rdy(src_rdy[5:0]), .src_data(src_data[95:0]), .err_clr(err_clr),
        .bus_data(bus_data6), .bus_valid(bus_valid6), .grant(grant6), .owner(owner6),
        .err_sel(err_sel6), .err_timeout(err_to6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic mstate_t reset_state();
        mstate_t r;
        r.bus_data  = '0;
        r.bus_valid = 1'b0;
        r.grant     = '0;
        r.owner     = '0;
        r.err_sel   = 1'b0;
        r.err_to    = 1'b0;
        r.fsm       = 0;
        r.last      = 0;
        r.cnt       = 0;
        r.mode_prev = 1'b0;
        return r;
    endfunction

    // Reference behaviour written directly from the block description.
    function automatic mstate_t model_next(input mstate_t s, input int nsrc);
        mstate_t n;
        bit      xfer;
        bit      set_sel;
        bit      set_to;
        bit      repick;
        int      xi;
        int      pick;
        int      idx;
        n       = s;
        xfer    = 0;
        set_sel = 0;
        set_to  = 0;
        repick  = 0;
        xi      = 0;
        n.bus_valid = 1'b0;
        if (mode !== s.mode_prev) begin
            n.mode_prev = mode;
            n.fsm       = 0;
            n.owner     = '0;
        end else if (mode == 1'b0) begin
            n.fsm = 0;
            if (sel == 0) begin
                n.owner = '0;
            end else if (int'(sel) >= nsrc) begin
                n.owner = '0;
                set_sel = 1;
            end else begin
                n.owner = sel;
                if (src_rdy[sel]) begin
                    xfer = 1;
                    xi   = int'(sel);
                end
            end
        end else begin
            if (s.fsm == 1) begin
                if (src_rdy[s.owner]) begin
                    xfer  = 1;
                    xi    = int'(s.owner);
                    n.fsm = 2;
                end else if (!req[s.owner]) begin
                    n.fsm   = 0;
                    n.owner = '0;
                end else if (s.cnt == WAIT_MAX) begin
                    set_to  = 1;
                    n.fsm   = 0;
                    n.owner = '0;
                end else begin
                    n.cnt = s.cnt + 1;
                end
            end else if (s.fsm == 2 && lock && req[s.owner]) begin
                if (src_rdy[s.owner]) begin
                    xfer = 1;
                    xi   = int'(s.owner);
                end else begin
                    n.cnt = 1;
                    n.fsm = 1;
                end
            end else begin
                repick = 1;
            end
            if (repick) begin
                pick = 0;
                for (int k = 1; k <= nsrc; k++) begin
                    idx = (s.last + k) % nsrc;
                    if (pick == 0 && idx != 0 && req[idx]) pick = idx;
                end
                if (pick == 0) begin
                    n.fsm   = 0;
                    n.owner = '0;
                end else begin
                    n.owner = 3'(pick);
                    n.last  = pick;
                    if (src_rdy[pick]) begin
                        xfer  = 1;
                        xi    = pick;
                        n.fsm = 2;
                    end else begin
                        n.cnt = 1;
                        n.fsm = 1;
                    end
                end
            end
        end
        n.grant = (n.owner == 0) ? 8'h00 : (8'h01 << n.owner);
        if (xfer) begin
            n.bus_valid = 1'b1;
            n.bus_data  = src_data[xi*16 +: 16];
        end
        if (err_clr) begin
            n.err_sel = 1'b0;
            n.err_to  = 1'b0;
        end
        if (set_sel) n.err_sel = 1'b1;
        if (set_to)  n.err_to  = 1'b1;
        return n;
    endfunction

    task automatic cmp8(input mstate_t e, input string tag);
        check({tag, ".bus_data8"},  32'(bus_data8),  32'(e.bus_data));
        check({tag, ".bus_valid8"}, 32'(bus_valid8), 32'(e.bus_valid));
        check({tag, ".grant8"},     32'(grant8),     32'(e.grant));
        check({tag, ".owner8"},     32'(owner8),     32'(e.owner));
        check({tag, ".err_sel8"},   32'(err_sel8),   32'(e.err_sel));
        check({tag, ".err_to8"},    32'(err_to8),    32'(e.err_to));
    endtask

    task automatic cmp6(input mstate_t e, input string tag);
        check({tag, ".bus_data6"},  32'(bus_data6),  32'(e.bus_data));
        check({tag, ".bus_valid6"}, 32'(bus_valid6), 32'(e.bus_valid));
        check({tag, ".grant6"},     32'({2'b00, grant6}), 32'(e.grant));
        check({tag, ".owner6"},     32'(owner6),     32'(e.owner));
        check({tag, ".err_sel6"},   32'(err_sel6),   32'(e.err_sel));
        check({tag, ".err_to6"},    32'(err_to6),    32'(e.err_to));
    endtask

    // Inputs are already set by the caller; refresh data, predict, clock, compare.
    task automatic step();
        mstate_t e8, e6;
        for (int i = 0; i < 8; i++) src_data[i*16 +: 16] = 16'($urandom);
        if (beef_mode) src_data[3*16 +: 16] = 16'hBEEF;
        e8 = model_next(m8, 8);
        e6 = model_next(m6, 6);
        m8 = e8;
        m6 = e6;
        q8.push_back(e8);
        q6.push_back(e6);
        @(posedge clk);
        #1;
        cmp8(q8.pop_front(), "sb");
        cmp6(q6.pop_front(), "sb");
    endtask

    initial begin
        logic [2:0] rr_seq [9];
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        req       = '0;
        lock      = 1'b0;
        src_rdy   = '0;
        src_data  = '0;
        err_clr   = 1'b0;
        beef_mode = 1'b0;
        m8 = reset_state();
        m6 = reset_state();

        @(posedge clk);
        #1;
        cmp8(reset_state(), "reset");
        cmp6(reset_state(), "reset");
        #2 rst_n = 1'b1;

        // Legacy select of slot 3, then idle select holds the data.
        beef_mode = 1'b1;
        src_rdy   = 8'hFF;
        sel       = 3'd3;
        step();
        check("t1_data", 32'(bus_data8), 32'h0000_BEEF);
        check("t1_grant", 32'(grant8), 32'h08);
        sel = 3'd0;
        step();
        check("t1_hold", 32'(bus_data8), 32'h0000_BEEF);
        check("t1_valid_low", 32'(bus_valid8), 32'h0);
        beef_mode = 1'b0;

        // Illegal select on the 6-slot instance, clear, and clear colliding with set.
        sel = 3'd7;
        step();
        check("t2_err_sel6", 32'(err_sel6), 32'h1);
        sel = 3'd6;
        step();
        sel     = 3'd0;
        err_clr = 1'b1;
        step();
        check("t2_cleared", 32'(err_sel6), 32'h0);
        sel = 3'd7;
        step();
        check("t2_set_wins", 32'(err_sel6), 32'h1);
        err_clr = 1'b0;
        sel     = 3'd5;
        src_rdy = 8'hDF;
        step();
        sel = 3'd0;
        src_rdy = 8'hFF;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Round robin among 2, 5, 7 with everyone ready.
        mode = 1'b1;
        req  = 8'b1010_0100;
        step();
        check("t3_switch_grant", 32'(grant8), 32'h0);
        rr_seq = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7};
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("t3_owner%0d", i), 32'(owner8), 32'(rr_seq[i]));
            check($sformatf("t3_valid%0d", i), 32'(bus_valid8), 32'h1);
        end

        // Lock keeps owner 4 until its request drops.
        req = '0;
        step();
        lock = 1'b1;
        req  = 8'b0001_0000;
        step();
        req = 8'b0001_0010;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t4_locked%0d", i), 32'(owner8), 32'h4);
        end
        req = 8'b0000_0010;
        step();
        check("t4_handover", 32'(owner8), 32'h1);

        // Stalled source 7 times out after WAIT_MAX cycles in WAIT.
        lock = 1'b0;
        req  = '0;
        step();
        src_rdy = 8'h7F;
        req     = 8'h80;
        for (int i = 0; i < WAIT_MAX; i++) step();
        check("t5_still_waiting", 32'(owner8), 32'h7);
        check("t5_no_err_yet", 32'(err_to8), 32'h0);
        step();
        check("t5_timeout", 32'(err_to8), 32'h1);
        check("t5_released", 32'(grant8), 32'h0);
        req     = '0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        req     = 8'h80;
        for (int i = 0; i < 9; i++) step();
        src_rdy = 8'hFF;
        step();
        check("t5_late_ready", 32'(bus_valid8), 32'h1);
        check("t5_late_no_err", 32'(err_to8), 32'h0);

        // Asynchronous reset mid-burst.
        req = 8'b0010_0100;
        for (int i = 0; i < 3; i++) step();
        #2 rst_n = 1'b0;
        #1;
        cmp8(reset_state(), "async_rst");
        cmp6(reset_state(), "async_rst");
        m8 = reset_state();
        m6 = reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Mode toggle while waiting on a stalled source.
        req     = 8'h80;
        src_rdy = 8'h7F;
        step();
        step();
        mode = 1'b0;
        sel  = 3'd3;
        step();
        check("t6_toggle_grant", 32'(grant8), 32'h0);
        check("t6_toggle_valid", 32'(bus_valid8), 32'h0);
        step();
        check("t6_legacy_owner", 32'(owner8), 32'h3);
        check("t6_legacy_valid", 32'(bus_valid8), 32'h1);

        // Random mixed traffic.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel     = 3'($urandom);
            req     = 8'($urandom);
            lock    = 1'($urandom);
            src_rdy = 8'($urandom) | 8'($urandom);
            err_clr = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
